// File: rtl/tile_cl_pkg.sv
// Cache-line constants and types shared by the tile mesh node and its local write sink.
// Size word layout: {shared, exclusive, phymsk}.
package tile_cl_pkg;
   localparam int ADDR_W      = 37;
   localparam int PMSK_W      = 36;
   localparam int DATA_W      = 528;
   localparam int SIZE_W      = PMSK_W + 2;
   localparam int SIZE_SHARED = PMSK_W + 1;
   localparam int SIZE_EXCL   = PMSK_W;

   // Buffer entry control fields; line data lives in a separate RAM.
   typedef struct packed {
      logic              vld;
      logic              expun;
      logic [ADDR_W-1:0] addr;
      logic [SIZE_W-1:0] size;
   } cl_entry_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BEAT = 2'd1,
      S_INV  = 2'd2
   } sink_state_e;
endpackage

// File: rtl/tile_cl_write_sink_if.sv
// Delivered-request stream, L2 bank write port and status for the tile write sink.
// Bank handshake: a beat transfers on a cycle with bank_valid & bank_ready; while bank_valid=1 and bank_ready=0 every bank_* signal holds. The request stream has no ready.
interface tile_cl_write_sink_if #(
   parameter int BEATS = 4
) ();
   import tile_cl_pkg::*;
   localparam int BEAT_W = DATA_W / BEATS;
   localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic              in_valid;
   logic              in_expun;
   logic [DATA_W-1:0] in_data;
   logic [ADDR_W-1:0] in_addr;
   logic [SIZE_W-1:0] in_size;
   logic              almost_full;
   logic              bank_valid;
   logic              bank_ready;
   logic [ADDR_W-1:0] bank_addr;
   logic [BIDX_W-1:0] bank_beat;
   logic [BEAT_W-1:0] bank_data;
   logic              bank_last;
   logic              bank_inv;
   logic              bank_shared;
   logic              bank_excl;
   logic [PMSK_W-1:0] bank_phymsk;
   logic              overflow;
   logic [7:0]        drop_cnt;

   modport master (
      output in_valid, in_expun, in_data, in_addr, in_size, bank_ready,
      input  almost_full, bank_valid, bank_addr, bank_beat, bank_data, bank_last,
             bank_inv, bank_shared, bank_excl, bank_phymsk, overflow, drop_cnt
   );

   modport slave (
      input  in_valid, in_expun, in_data, in_addr, in_size, bank_ready,
      output almost_full, bank_valid, bank_addr, bank_beat, bank_data, bank_last,
             bank_inv, bank_shared, bank_excl, bank_phymsk, overflow, drop_cnt
   );
endinterface

// File: rtl/tile_cl_sink_ram.sv
// Line-data storage for the write sink: one write port, one asynchronous read port
// that returns the selected beat slice of the addressed line.
module tile_cl_sink_ram
   import tile_cl_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int BEATS  = 4,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1,
   parameter int BEAT_W = DATA_W / BEATS
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [PTR_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [PTR_W-1:0]  i_raddr,
   input  logic [BIDX_W-1:0] i_rbeat,
   output logic [BEAT_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr][int'(i_rbeat)*BEAT_W +: BEAT_W];
endmodule

// File: rtl/tile_cl_write_sink.sv
// Tile-local sink for delivered cache-line requests: captures without backpressure into a
// coalescing circular buffer and drains each entry to the L2 bank as data beats or one invalidate.
module tile_cl_write_sink
   import tile_cl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int BEATS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   tile_cl_write_sink_if.slave  io,
   output sink_state_e          o_dbg_state
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BEAT_W = DATA_W / BEATS;
   localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);

   cl_entry_t         r_ent [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [BIDX_W-1:0] r_beat;
   sink_state_e       r_state;
   logic              r_afull, r_ovf;
   logic [7:0]        r_drop;

   sink_state_e       w_state_nxt;
   logic [BIDX_W-1:0] w_beat_nxt;
   logic              w_draining, w_deq, w_hit, w_coal, w_full, w_alloc, w_drop;
   logic              w_take_next, w_nxt_vld, w_nxt_exp;
   logic [PTR_W-1:0]  w_hit_idx, w_rd_nxt;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [BEAT_W-1:0] w_rdata;

   // The head entry is draining whenever the FSM is out of IDLE.
   assign w_draining = (r_state != S_IDLE);
   assign w_deq      = w_draining && io.bank_ready && ((r_state == S_INV) || (r_beat == LAST_BEAT));

   // Coalescing CAM: pending, non-draining data entries with the same line address.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_ent[i].vld && !r_ent[i].expun && (r_ent[i].addr == io.in_addr) &&
             !(w_draining && (PTR_W'(i) == r_rd_ptr))) begin
            w_hit     = 1'b1;
            w_hit_idx = PTR_W'(i);
         end
      end
   end

   // A buffer that frees its head this cycle can accept a new request into that slot.
   assign w_coal      = io.in_valid && !io.in_expun && w_hit;
   assign w_full      = ((r_count - CNT_W'(w_deq)) == CNT_W'(DEPTH));
   assign w_alloc     = io.in_valid && !w_coal && !w_full;
   assign w_drop      = io.in_valid && !w_coal && w_full;
   assign w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_deq);
   assign w_rd_nxt    = w_deq ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

   // Head after this cycle, including a request being allocated straight into it.
   assign w_nxt_vld = r_ent[w_rd_nxt].vld || (w_alloc && (r_wr_ptr == w_rd_nxt));
   assign w_nxt_exp = (w_alloc && (r_wr_ptr == w_rd_nxt)) ? io.in_expun : r_ent[w_rd_nxt].expun;

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_take_next = 1'b0;
      case (r_state)
         S_IDLE: w_take_next = 1'b1;
         S_BEAT: begin
            if (io.bank_ready) begin
               if (r_beat == LAST_BEAT) w_take_next = 1'b1;
               else                     w_beat_nxt  = r_beat + BIDX_W'(1);
            end
         end
         S_INV:   if (io.bank_ready) w_take_next = 1'b1;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_take_next) begin
         w_beat_nxt  = '0;
         w_state_nxt = !w_nxt_vld ? S_IDLE : (w_nxt_exp ? S_INV : S_BEAT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_beat   <= '0;
         r_state  <= S_IDLE;
         r_afull  <= 1'b0;
         r_ovf    <= 1'b0;
         r_drop   <= '0;
      end else begin
         if (w_deq) r_ent[r_rd_ptr].vld <= 1'b0;
         if (w_coal) r_ent[w_hit_idx].size <= r_ent[w_hit_idx].size | io.in_size;
         // Allocation comes last so a full-buffer refill of the freed slot wins.
         if (w_alloc) begin
            r_ent[r_wr_ptr] <= '{vld: 1'b1, expun: io.in_expun, addr: io.in_addr, size: io.in_size};
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
         end
         r_rd_ptr <= w_rd_nxt;
         r_count  <= w_count_nxt;
         r_afull  <= (w_count_nxt >= CNT_W'(DEPTH - 1));
         r_state  <= w_state_nxt;
         r_beat   <= w_beat_nxt;
      end
   end

   tile_cl_sink_ram #(.DEPTH(DEPTH), .BEATS(BEATS)) u_ram (
      .clk     (clk),
      .i_we    (w_coal || w_alloc),
      .i_waddr (w_coal ? w_hit_idx : r_wr_ptr),
      .i_wdata (io.in_data),
      .i_raddr (r_rd_ptr),
      .i_rbeat (r_beat),
      .o_rdata (w_rdata)
   );

   assign io.bank_valid  = w_draining;
   assign io.bank_addr   = r_ent[r_rd_ptr].addr;
   assign io.bank_beat   = r_beat;
   assign io.bank_data   = w_rdata;
   assign io.bank_last   = (r_state == S_INV) || ((r_state == S_BEAT) && (r_beat == LAST_BEAT));
   assign io.bank_inv    = (r_state == S_INV);
   assign io.bank_shared = r_ent[r_rd_ptr].size[SIZE_SHARED];
   assign io.bank_excl   = r_ent[r_rd_ptr].size[SIZE_EXCL];
   assign io.bank_phymsk = r_ent[r_rd_ptr].size[PMSK_W-1:0];
   assign io.almost_full = r_afull;
   assign io.overflow    = r_ovf;
   assign io.drop_cnt    = r_drop;
   assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_tile_cl_write_sink.sv
// Bench for tile_cl_write_sink: directed scenarios plus random traffic, checked each cycle
// against a line-level queue model of the sink buffer.
module tb_tile_cl_write_sink;
   import tile_cl_pkg::*;
   localparam int DEPTH  = 4;
   localparam int BEATS  = 4;
   localparam int BEAT_W = DATA_W / BEATS;

   typedef struct {
      logic              expun;
      logic [ADDR_W-1:0] addr;
      logic [SIZE_W-1:0] size;
      logic [DATA_W-1:0] data;
   } line_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   sink_state_e dbg_state;
   tile_cl_write_sink_if #(.BEATS(BEATS)) bus ();

   tile_cl_write_sink #(.DEPTH(DEPTH), .BEATS(BEATS)) dut (
      .clk         (clk),
      .rst         (rst),
      .io          (bus.slave),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Scoreboard state: lines still owed to the bank, oldest first.
   line_t exp_q [$];
   int    m_beat    = 0;
   logic  exp_afull = 1'b0;
   logic  exp_ovf   = 1'b0;
   int    exp_drop  = 0;
   int    checks    = 0;
   int    errors    = 0;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor and reference model, evaluated mid-cycle when inputs and outputs are settled.
   always @(negedge clk) begin
      line_t h;
      int    hit;
      int    dq;
      if (rst) begin
         exp_q.delete();
         m_beat    = 0;
         exp_afull = 1'b0;
         exp_ovf   = 1'b0;
         exp_drop  = 0;
      end else begin
         chk("almost_full", DATA_W'(bus.almost_full), DATA_W'(exp_afull));
         chk("overflow", DATA_W'(bus.overflow), DATA_W'(exp_ovf));
         chk("drop_cnt", DATA_W'(bus.drop_cnt), DATA_W'(exp_drop));
         chk("bank_valid", DATA_W'(bus.bank_valid), DATA_W'(exp_q.size() > 0));
         dq = 0;
         if (bus.bank_valid && exp_q.size() > 0) begin
            h = exp_q[0];
            chk("bank_addr", DATA_W'(bus.bank_addr), DATA_W'(h.addr));
            chk("bank_inv", DATA_W'(bus.bank_inv), DATA_W'(h.expun));
            chk("bank_last", DATA_W'(bus.bank_last), DATA_W'(h.expun || m_beat == BEATS - 1));
            chk("bank_beat", DATA_W'(bus.bank_beat), DATA_W'(h.expun ? 0 : m_beat));
            chk("bank_size", DATA_W'({bus.bank_shared, bus.bank_excl, bus.bank_phymsk}), DATA_W'(h.size));
            if (!h.expun) chk("bank_data", DATA_W'(bus.bank_data), DATA_W'(h.data[m_beat*BEAT_W +: BEAT_W]));
            if (bus.bank_ready) begin
               if (h.expun || m_beat == BEATS - 1) begin
                  dq     = 1;
                  m_beat = 0;
               end else begin
                  m_beat++;
               end
            end
         end
         if (bus.in_valid) begin
            hit = -1;
            for (int i = 1; i < exp_q.size(); i++)
               if (!bus.in_expun && !exp_q[i].expun && exp_q[i].addr == bus.in_addr) hit = i;
            if (hit >= 0) begin
               exp_q[hit].data = bus.in_data;
               exp_q[hit].size = exp_q[hit].size | bus.in_size;
            end else if (exp_q.size() - dq < DEPTH) begin
               exp_q.push_back('{bus.in_expun, bus.in_addr, bus.in_size, bus.in_data});
            end else begin
               exp_ovf = 1'b1;
               if (exp_drop < 255) exp_drop++;
            end
         end
         if (dq != 0) void'(exp_q.pop_front());
         exp_afull = (exp_q.size() >= DEPTH - 1);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic expun, input logic [ADDR_W-1:0] addr,
                       input logic [SIZE_W-1:0] size, input logic [DATA_W-1:0] data);
      bus.in_valid = 1'b1;
      bus.in_expun = expun;
      bus.in_addr  = addr;
      bus.in_size  = size;
      bus.in_data  = data;
      step(1);
      bus.in_valid = 1'b0;
      bus.in_expun = 1'b0;
   endtask

   task automatic wait_beat(input int b);
      for (int n = 0; n < 50; n++) begin
         if (bus.bank_valid && int'(bus.bank_beat) == b) return;
         step(1);
      end
      chk("wait_beat_timeout", DATA_W'(0), DATA_W'(b + 1));
   endtask

   function automatic logic [DATA_W-1:0] ramp_data();
      logic [DATA_W-1:0] d;
      d = '0;
      for (int k = 0; k < BEATS; k++) d[k*BEAT_W +: BEAT_W] = {33{4'(k + 1)}};
      return d;
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      d = '0;
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
      d[DATA_W-1:512] = 16'($urandom);
      return d;
   endfunction

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_expun   = 1'b0;
      bus.in_addr    = '0;
      bus.in_size    = '0;
      bus.in_data    = '0;
      bus.bank_ready = 1'b1;
      step(3);
      rst = 1'b0;
      step(2);

      // Single write, ramp data
      send(1'b0, 37'h1234, {2'b00, 36'h1}, ramp_data());
      step(8);

      // Backpressure on beat 1
      send(1'b0, 37'h2000, {2'b10, 36'h5}, rand_data());
      wait_beat(1);
      bus.bank_ready = 1'b0;
      step(3);
      bus.bank_ready = 1'b1;
      step(8);

      // Coalesce behind a stalled head
      bus.bank_ready = 1'b0;
      send(1'b0, 37'h100, {2'b00, 36'h1}, rand_data());
      send(1'b0, 37'h40, {2'b01, 36'h3}, rand_data());
      send(1'b0, 37'h40, {2'b10, 36'hC}, rand_data());
      step(2);
      bus.bank_ready = 1'b1;
      step(12);

      // Expunge queued behind data for the same line
      send(1'b0, 37'h80, {2'b00, 36'h7}, rand_data());
      send(1'b1, 37'h80, {2'b00, 36'h0}, '0);
      step(10);

      // Overflow: six distinct lines against a stalled bank
      bus.bank_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(1'b0, 37'h1000 + 37'(i), {2'b00, 36'(i + 1)}, rand_data());
      step(2);
      bus.bank_ready = 1'b1;
      step(24);

      // Reset mid-drain, then a fresh line
      send(1'b0, 37'h3000, {2'b00, 36'h9}, rand_data());
      wait_beat(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
      send(1'b0, 37'h3100, {2'b01, 36'hA}, ramp_data());
      step(8);

      // Random traffic over a small address pool to provoke coalescing and drops
      for (int c = 0; c < 400; c++) begin
         bus.bank_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1)
            send(($urandom_range(0, 7) == 0), 37'(64 * $urandom_range(0, 5)),
                 {2'($urandom_range(0, 3)), 36'($urandom)}, rand_data());
         else
            step(1);
      end

      bus.bank_ready = 1'b1;
      for (int n = 0; n < 200 && (exp_q.size() != 0 || bus.bank_valid); n++) step(1);
      chk("drain_timeout", DATA_W'(exp_q.size()), DATA_W'(0));
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
